// File: rtl/apb_cmd_master.sv
// apb_cmd_master: valid/ready command FIFO feeding an APB3 initiator with pReady wait states.
// Optional ACCESS-phase timeout abort is enabled by defining APB_TIMEOUT_EN.
module apb_cmd_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              pClk,
  input  logic              pReset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              pSel,
  output logic              pEnable,
  output logic              pWrite,
  output logic [ADDR_W-1:0] pAddr,
  output logic [DATA_W-1:0] pWdata,
  input  logic [DATA_W-1:0] pReadData,
  input  logic              pReady
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 1 + ADDR_W + DATA_W;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_n;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic full, empty, push, pop, done, expired;
  logic hw;
  logic [ADDR_W-1:0] ha, addr_n;
  logic [DATA_W-1:0] hd, wd_n, rd_n;
  logic sel_n, en_n, wr_n, rv_n, err_n;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign cmd_ready = !full;
  assign push = cmd_valid && !full;
  assign busy = !empty || state != IDLE;
  assign {hw, ha, hd} = mem[rp[AW-1:0]];
  always_ff @(posedge pClk or posedge pReset)
    if (pReset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge pClk)
    if (push) mem[wp[AW-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign expired = state == ACCESS && !pReady && cnt == CW'(TIMEOUT);
  always_ff @(posedge pClk or posedge pReset)
    if (pReset) cnt <= '0;
    else if (state == SETUP) cnt <= CW'(1);
    else if (state == ACCESS && !pReady) cnt <= cnt + CW'(1);
`else
  assign expired = TIMEOUT < 0;
`endif
  assign done = state == ACCESS && (pReady || expired);
  always_comb begin
    state_n = state;
    sel_n = pSel;
    en_n = pEnable;
    wr_n = pWrite;
    addr_n = pAddr;
    wd_n = pWdata;
    rv_n = 1'b0;
    rd_n = rsp_rdata;
    err_n = rsp_err;
    pop = 1'b0;
    if (done) begin
      rv_n = 1'b1;
      rd_n = (pWrite || expired) ? '0 : pReadData;
      err_n = expired;
    end
    if ((state == IDLE || done) && !empty) begin
      pop = 1'b1;
      state_n = SETUP;
      sel_n = 1'b1;
      en_n = 1'b0;
      wr_n = hw;
      addr_n = ha;
      wd_n = hw ? hd : '0;
    end else if (done) begin
      state_n = IDLE;
      sel_n = 1'b0;
      en_n = 1'b0;
      wr_n = 1'b0;
      addr_n = '0;
      wd_n = '0;
    end else if (state == SETUP) begin
      state_n = ACCESS;
      en_n = 1'b1;
    end
  end
  always_ff @(posedge pClk or posedge pReset)
    if (pReset) begin
      state <= IDLE;
      pSel <= 1'b0;
      pEnable <= 1'b0;
      pWrite <= 1'b0;
      pAddr <= '0;
      pWdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_n;
      pSel <= sel_n;
      pEnable <= en_n;
      pWrite <= wr_n;
      pAddr <= addr_n;
      pWdata <= wd_n;
      rsp_valid <= rv_n;
      rsp_rdata <= rd_n;
      rsp_err <= err_n;
    end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed table, corner sequences and random traffic against a transaction-level model.
module tb_apb_cmd_master;
  localparam int DEPTH = 4;
  localparam int TO = 16;
  logic pClk = 0, pReset = 0, cmd_valid = 0, cmd_write = 0, pReady = 1;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0, pReadData = 0;
  logic cmd_ready, rsp_valid, rsp_err, busy, pSel, pEnable, pWrite;
  logic [31:0] rsp_rdata, pAddr, pWdata;

  apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .pClk(pClk), .pReset(pReset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .pSel(pSel), .pEnable(pEnable), .pWrite(pWrite), .pAddr(pAddr), .pWdata(pWdata),
    .pReadData(pReadData), .pReady(pReady)
  );

  always #5 pClk = ~pClk;

  typedef struct packed {logic w; logic [31:0] a; logic [31:0] d;} cmd_t;
  typedef struct {logic w; logic [31:0] a; logic [31:0] d; logic [31:0] rd; int waits; logic [31:0] exp_rd;} vec_t;
  cmd_t exp_q[$];
  vec_t vt[5];
  logic [31:0] b2b[3];
  int vectors = 0, miscompares = 0, accepted = 0, setups = 0, acc_n = 0;
  logic acc_last = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    accepted = 0;
    setups = 0;
    acc_n = 0;
  endtask

  // One clock: judge the cycle ending at this edge from bus rules, then check outputs after it.
  task automatic tick();
    logic acc, done, err;
    logic [31:0] erd;
    cmd_t c;
    acc = cmd_valid && cmd_ready;
    done = 0;
    err = 0;
    erd = 0;
    if (pSel && pEnable) begin
      acc_n++;
      done = pReady;
`ifdef APB_TIMEOUT_EN
      if (!pReady && acc_n == TO) begin
        done = 1;
        err = 1;
      end
`endif
    end
    if (done) begin
      acc_n = 0;
      chk("xfer_queued", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        c = exp_q.pop_front();
        chk("xfer_write", pWrite, c.w);
        chk("xfer_addr", pAddr, c.a);
        chk("xfer_wdata", pWdata, c.w ? c.d : 32'h0);
        erd = (c.w || err) ? 32'h0 : pReadData;
      end
    end
    if (acc) begin
      exp_q.push_back({cmd_write, cmd_addr, cmd_wdata});
      accepted++;
    end
    acc_last = acc;
    @(posedge pClk);
    #1;
    chk("rsp_valid", rsp_valid, done);
    if (done) begin
      chk("rsp_rdata", rsp_rdata, erd);
      chk("rsp_err", rsp_err, err);
    end
    if (pSel && !pEnable) setups++;
    chk("cmd_ready", cmd_ready, (accepted - setups) < DEPTH);
    chk("busy", busy, (accepted - setups) > 0 || pSel);
    if (!pSel) chk("idle_bus", {pEnable, pWrite, |pAddr, |pWdata}, 0);
  endtask

  task automatic drain();
    cmd_valid = 0;
    pReady = 1;
    for (int t = 0; t < 100 && (busy || exp_q.size() > 0); t++) tick();
    chk("drain_busy", busy, 0);
    chk("drain_queue", exp_q.size(), 0);
  endtask

  initial begin
    int n, sel_cnt, first, last, rsp_cnt;
    vt[0] = '{1'b1, 32'h0, 32'h0000_000A, 32'h0, 0, 32'h0};
    vt[1] = '{1'b0, 32'h3, 32'h0, 32'h0000_0055, 0, 32'h0000_0055};
    vt[2] = '{1'b1, 32'h10, 32'h1234_5678, 32'hFFFF_FFFF, 3, 32'h0};
    vt[3] = '{1'b0, 32'h20, 32'h0000_CAFE, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF};
    vt[4] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0, 1, 32'h0};
    b2b[0] = 32'hA;
    b2b[1] = 32'hF;
    b2b[2] = 32'h7;

    #1 pReset = 1;
    repeat (2) @(posedge pClk);
    #1;
    chk("rst_sel", pSel, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    pReset = 0;

    foreach (vt[i]) begin
      cmd_valid = 1;
      cmd_write = vt[i].w;
      cmd_addr = vt[i].a;
      cmd_wdata = vt[i].d;
      pReadData = vt[i].rd;
      pReady = vt[i].waits == 0;
      tick();
      cmd_valid = 0;
      chk("t_sel_late", pSel, 0);
      tick();
      chk("t_sel", pSel, 1);
      chk("t_en0", pEnable, 0);
      chk("t_write", pWrite, vt[i].w);
      chk("t_addr", pAddr, vt[i].a);
      chk("t_wdata", pWdata, vt[i].w ? vt[i].d : 32'h0);
      tick();
      chk("t_en", pEnable, 1);
      for (int k = 0; k < vt[i].waits; k++) begin
        tick();
        chk("t_wait", {pSel, pEnable, pAddr == vt[i].a}, 3'b111);
      end
      pReady = 1;
      tick();
      chk("t_rsp", rsp_valid, 1);
      chk("t_rdata", rsp_rdata, vt[i].exp_rd);
      chk("t_bus_off", pSel, 0);
      tick();
      chk("t_rsp_once", rsp_valid, 0);
    end

    // three back-to-back writes
    pReady = 1;
    sel_cnt = 0; first = -1; last = -1; rsp_cnt = 0;
    for (int t = 0; t < 14; t++) begin
      cmd_valid = t < 3;
      cmd_write = 1;
      cmd_addr = 0;
      cmd_wdata = (t < 3) ? b2b[t] : 32'h0;
      tick();
      if (pSel) begin
        sel_cnt++;
        if (first < 0) first = t;
        last = t;
      end
      if (rsp_valid) rsp_cnt++;
    end
    cmd_valid = 0;
    chk("b2b_sel_cycles", sel_cnt, 6);
    chk("b2b_sel_span", last - first + 1, 6);
    chk("b2b_rsp_cnt", rsp_cnt, 3);

    // fill the FIFO behind a stalled transfer
    pReady = 0;
    n = 0;
    cmd_valid = 1;
    cmd_write = 1;
    for (int t = 0; t < 20 && n < 5; t++) begin
      cmd_addr = 32'h100 + n * 4;
      cmd_wdata = n;
      tick();
      if (acc_last) n++;
    end
    chk("full_accepted", n, 5);
    chk("full_ready", cmd_ready, 0);
    cmd_addr = 32'h114;
    cmd_wdata = 5;
    repeat (3) begin
      tick();
      chk("full_block", acc_last, 0);
    end
    pReady = 1;
    tick();
    chk("full_ready_rise", cmd_ready, 1);
    tick();
    chk("full_accept6", acc_last, 1);
    drain();

`ifdef APB_TIMEOUT_EN
    pReady = 0;
    cmd_valid = 1;
    cmd_write = 0;
    cmd_addr = 32'h40;
    tick();
    cmd_addr = 32'h44;
    tick();
    cmd_valid = 0;
    n = 0;
    for (int t = 0; t < 60 && !rsp_valid; t++) begin
      if (pSel && pEnable) n++;
      tick();
    end
    chk("to_cycles", n, TO);
    chk("to_rsp", rsp_valid, 1);
    chk("to_err", rsp_err, 1);
    chk("to_rdata", rsp_rdata, 0);
    chk("to_next", pSel && !pEnable, 1);
    drain();
`endif

    // reset during an ACCESS wait state with one command still queued
    pReady = 0;
    cmd_valid = 1;
    cmd_write = 0;
    cmd_addr = 32'h8;
    tick();
    cmd_addr = 32'hC;
    tick();
    cmd_valid = 0;
    tick();
    tick();
    chk("mid_access", pSel && pEnable, 1);
    #2 pReset = 1;
    #1;
    chk("mrst_sel", pSel, 0);
    chk("mrst_en", pEnable, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_rsp", rsp_valid, 0);
    chk("mrst_ready", cmd_ready, 1);
    @(posedge pClk);
    #1;
    pReset = 0;
    model_clear();
    pReady = 1;
    repeat (3) tick();
    chk("mrst_empty", busy, 0);

    for (int t = 0; t < 600; t++) begin
      cmd_valid = $urandom_range(0, 1);
      cmd_write = $urandom_range(0, 1);
      cmd_addr = $urandom;
      cmd_wdata = $urandom;
      pReadData = $urandom;
      pReady = (acc_n >= 5) ? 1'b1 : ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
